// File: rtl/alu_pkg.sv
// alu_pkg: shared funct3/funct7 encodings and helpers for the RV64I ALU slice.
package alu_pkg;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: combinational RV64M multiply/divide unit, used only when ALU_MULDIV_EN is defined.
module alu_muldiv
    import alu_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic [2:0]  funct3_i,
    input  logic        width_32_i,
    output logic [63:0] res_o
);
    logic               sa, sb, sgn, dz, ovf;
    logic [127:0]       ax, bx, prod;
    logic [63:0]        da, db, q, r, raw;
    logic signed [63:0] qs, rs;

    always_comb begin
        sa   = funct3_i == F3_MULH || funct3_i == F3_MULHSU;
        sb   = funct3_i == F3_MULH;
        ax   = {{64{sa & a_i[63]}}, a_i};
        bx   = {{64{sb & b_i[63]}}, b_i};
        prod = ax * bx;
        sgn  = funct3_i == F3_DIV || funct3_i == F3_REM;
        // W divides widen the 32-bit operands so one 64-bit divider serves both modes
        da   = width_32_i ? (sgn ? sext32(a_i[31:0]) : {32'b0, a_i[31:0]}) : a_i;
        db   = width_32_i ? (sgn ? sext32(b_i[31:0]) : {32'b0, b_i[31:0]}) : b_i;
        dz   = db == '0;
        ovf  = sgn && da == {1'b1, 63'b0} && db == '1;
        qs   = $signed(da) / $signed(db);
        rs   = $signed(da) % $signed(db);
        q    = dz ? '1 : ovf ? da : sgn ? qs : da / db;
        r    = dz ? da : ovf ? '0 : sgn ? rs : da % db;
        case (funct3_i)
            F3_MUL:                      raw = prod[63:0];
            F3_MULH, F3_MULHSU, F3_MULHU: raw = prod[127:64];
            F3_DIV, F3_DIVU:             raw = q;
            default:                     raw = r;
        endcase
        res_o = width_32_i ? sext32(raw[31:0]) : raw;
    end
endmodule

// File: rtl/alu.sv
// alu: RV64I EX-stage ALU with registered result, zero flag and valid.
// Define ALU_MULDIV_EN to add the RV64M ops selected by funct7 == 0000001.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            in_valid_i,
    input  logic            hold_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic            width_32_i,
    input  logic            op_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            out_valid_o
);
    logic                  alt, is_md;
    logic [5:0]            shamt;
    logic [XLEN-1:0]       sr_src, base, res_d, md_res;
    logic signed [XLEN-1:0] sra;
    logic [XLEN-1:0]       result_q;
    logic                  zero_q, valid_q;

`ifdef ALU_MULDIV_EN
    alu_muldiv u_muldiv (
        .a_i       (a_i),
        .b_i       (b_i),
        .funct3_i  (funct3_i),
        .width_32_i(width_32_i),
        .res_o     (md_res)
    );
    assign is_md = funct7_i == F7_MULDIV;
`else
    assign md_res = '0;
    assign is_md  = 1'b0;
`endif

    always_comb begin
        alt    = |(funct7_i & F7_ALT);
        shamt  = {~width_32_i & b_i[5], b_i[4:0]};
        // W right shifts see only a[31:0], zero- or sign-filled above
        sr_src = width_32_i ? {{32{alt & a_i[31]}}, a_i[31:0]} : a_i;
        sra    = $signed(sr_src) >>> shamt;
        case (funct3_i)
            F3_ADD:  base = alt ? a_i - b_i : a_i + b_i;
            F3_SLL:  base = a_i << shamt;
            F3_SLT:  base = {63'b0, $signed(a_i) < $signed(b_i)};
            F3_SLTU: base = {63'b0, a_i < b_i};
            F3_XOR:  base = a_i ^ b_i;
            F3_SR:   base = alt ? sra : sr_src >> shamt;
            F3_OR:   base = a_i | b_i;
            default: base = a_i & b_i;
        endcase
        res_d = op_i ? a_i + b_i : is_md ? md_res : width_32_i ? sext32(base[31:0]) : base;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else if (!hold_i) begin
            result_q <= res_d;
            zero_q   <= res_d == '0;
            valid_q  <= in_valid_i;
        end
    end

    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign out_valid_o = valid_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for alu.
module tb_alu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, hold = 1'b0, width_32 = 1'b0, op = 1'b0;
    logic [63:0] a = '0, b = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [63:0] result;
    logic        zero, out_valid;
    int          checks = 0, errors = 0;

    alu dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .in_valid_i (in_valid),
        .hold_i     (hold),
        .a_i        (a),
        .b_i        (b),
        .funct3_i   (funct3),
        .funct7_i   (funct7),
        .width_32_i (width_32),
        .op_i       (op),
        .result_o   (result),
        .zero_o     (zero),
        .out_valid_o(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic run(input logic w, input logic o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] x, input logic [63:0] y);
        in_valid = 1'b1;
        width_32 = w;
        op       = o;
        funct3   = f3;
        funct7   = f7;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic w, input logic o, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] exp);
        run(w, o, f3, f7, x, y);
        check(tag, result, exp);
        check({tag, "_zero"}, {63'b0, zero}, {63'b0, exp == '0});
    endtask

    initial begin
        #12;
        check("rst_result", result, 64'h0);
        check("rst_zero", {63'b0, zero}, 64'h1);
        check("rst_valid", {63'b0, out_valid}, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        run(0, 0, 3'b000, 7'h00, 64'd2, 64'd3);
        check("add5", result, 64'h5);
        check("add5_valid", {63'b0, out_valid}, 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_result", result, 64'h0);
        check("async_rst_zero", {63'b0, zero}, 64'h1);
        check("async_rst_valid", {63'b0, out_valid}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        alu_vec("add_wrap", 0, 0, 3'b000, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0);
        check("add_wrap_valid", {63'b0, out_valid}, 64'h1);
        alu_vec("sub", 0, 0, 3'b000, 7'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        alu_vec("addw", 1, 0, 3'b000, 7'h00, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
        alu_vec("sra63", 0, 0, 3'b101, 7'h20, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_vec("srl63", 0, 0, 3'b101, 7'h00, 64'h8000_0000_0000_0000, 64'd63, 64'h1);
        alu_vec("slt", 0, 0, 3'b010, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1);
        alu_vec("sltu", 0, 0, 3'b011, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0);
        alu_vec("force_add", 0, 1, 3'b100, 7'h00, 64'h1000, 64'h10, 64'h1010);
        alu_vec("sll_mask", 0, 0, 3'b001, 7'h00, 64'h1, 64'h41, 64'h2);
        alu_vec("xor", 0, 0, 3'b100, 7'h00, 64'hF0F0, 64'hFF00, 64'h0FF0);
        alu_vec("or", 0, 0, 3'b110, 7'h00, 64'hF0F0, 64'hFF00, 64'hFFF0);
        alu_vec("and", 0, 0, 3'b111, 7'h00, 64'hF0F0, 64'hFF00, 64'hF000);
        alu_vec("sllw", 1, 0, 3'b001, 7'h00, 64'h1, 64'd31, 64'hFFFF_FFFF_8000_0000);
        alu_vec("srlw", 1, 0, 3'b101, 7'h00, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000);
        alu_vec("sraw", 1, 0, 3'b101, 7'h20, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
        alu_vec("xorw_sext", 1, 0, 3'b100, 7'h00, 64'h1_0000_0000, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000);
`ifdef ALU_MULDIV_EN
        alu_vec("mul", 0, 0, 3'b000, 7'h01, 64'd2, 64'd3, 64'h6);
        alu_vec("div0", 0, 0, 3'b100, 7'h01, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_vec("rem_ovf", 0, 0, 3'b110, 7'h01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        alu_vec("div_ovf", 0, 0, 3'b100, 7'h01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000);
        alu_vec("mulhu", 0, 0, 3'b011, 7'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE);
        alu_vec("div_neg", 0, 0, 3'b100, 7'h01, -64'sd7, 64'd2, -64'sd3);
        alu_vec("remu0", 0, 0, 3'b111, 7'h01, 64'd9, 64'd0, 64'd9);
`else
        alu_vec("f7_bit0_ignored", 0, 0, 3'b000, 7'h01, 64'd2, 64'd3, 64'h5);
`endif

        alu_vec("pre_hold", 0, 0, 3'b110, 7'h00, 64'h1234, 64'h0, 64'h1234);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            run(0, 0, 3'b000, 7'h00, 64'(i + 100), 64'd7);
            in_valid = 1'b0;
            check("hold_result", result, 64'h1234);
            check("hold_valid", {63'b0, out_valid}, 64'h1);
        end
        hold = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bubble_valid", {63'b0, out_valid}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
